// File: rtl/cyphertext_fifo.sv
// ---------------------------------------------------------------------------
// cyphertext_fifo
//   Circular result buffer between the AES encryption core and its consumer.
//   Every finish_i pulse writes ciphertext_i into the buffer. The consumer
//   drains the buffer through a valid/ready read port. The block tracks
//   occupancy and a sticky overflow flag. It also keeps a registered copy of
//   the last ciphertext that was accepted.
//
//   Optional feature macro: CYPHER_FIFO_AF_EN
//     When defined, the block adds the almost_full_o port:
//     almost_full_o = (count_o >= AF_THRESH).
//     The encryption controller uses it to stall before the buffer overflows.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_ni        in   asynchronous active-low reset
//   clear_i       in   synchronous flush of pointers, count and overflow
//   finish_i      in   write strobe, ciphertext_i valid
//   ciphertext_i  in   ciphertext word from the encryption core
//   rd_ready_i    in   consumer accepts the head entry
//   rd_valid_o    out  buffer non-empty, rd_data_o valid
//   rd_data_o     out  head entry (combinational read)
//   last_q_o      out  most recently accepted ciphertext
//   count_o       out  occupancy, 0..DEPTH
//   full_o        out  count_o == DEPTH
//   overflow_o    out  sticky, a write was dropped
//   almost_full_o out  count_o >= AF_THRESH (CYPHER_FIFO_AF_EN only)
// ---------------------------------------------------------------------------
module cyphertext_fifo #(
  parameter int TEXT_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  finish_i,
  input  logic [TEXT_WIDTH-1:0] ciphertext_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [TEXT_WIDTH-1:0] rd_data_o,
  output logic [TEXT_WIDTH-1:0] last_q_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  overflow_o
`ifdef CYPHER_FIFO_AF_EN
  ,
  output logic                  almost_full_o
`endif
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_STEP   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO   = ADDR_WIDTH'(0);

  // Illegal parameter sets are rejected at elaboration. AF_THRESH is
  // checked even when the almost-full output is compiled out, so that
  // enabling the feature later cannot expose a bad value.
  if ((DEPTH < 2) || ((1 << ADDR_WIDTH) != DEPTH) ||
      (AF_THRESH < 1) || (AF_THRESH > DEPTH - 1)) begin : g_param_check
    $error("cyphertext_fifo: illegal DEPTH/ADDR_WIDTH/AF_THRESH");
  end

  logic [TEXT_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  overflow_r;
  logic [TEXT_WIDTH-1:0] last_q_r;

  logic push_s;
  logic pop_s;
  logic drop_s;

  // Handshake decode. When the buffer is full, a write is accepted only if a
  // pop frees an entry in the same cycle.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (count_r != CNT_ZERO) begin
      pop_s = rd_ready_i;
    end else begin
      pop_s = 1'b0;
    end
    if (finish_i) begin
      push_s = (count_r != FULL_COUNT) || pop_s;
      drop_s = (count_r == FULL_COUNT) && !pop_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Storage array, written on each accepted push. It has no reset.
  always_ff @(posedge clk_i) begin
    if (push_s && !clear_i) begin
      mem_r[wr_ptr_r] <= ciphertext_i;
    end
  end

  // Pointers, occupancy, overflow flag and last-accepted copy. clear_i wins
  // over push and pop. last_q is deliberately kept across a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      last_q_r   <= {TEXT_WIDTH{1'b0}};
    end else if (clear_i) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_STEP;
        last_q_r <= ciphertext_i;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_STEP;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_STEP;
        2'b01:   count_r <= count_r - CNT_STEP;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_valid_o = (count_r != CNT_ZERO);
  assign full_o     = (count_r == FULL_COUNT);
  assign count_o    = count_r;
  assign overflow_o = overflow_r;
  assign last_q_o   = last_q_r;
  assign rd_data_o  = mem_r[rd_ptr_r];

`ifdef CYPHER_FIFO_AF_EN
  assign almost_full_o = (count_r >= (ADDR_WIDTH+1)'(AF_THRESH));
`endif

endmodule

// File: tb/tb_cyphertext_fifo.sv
// ---------------------------------------------------------------------------
// tb_cyphertext_fifo
//   Self-checking bench for cyphertext_fifo with the default parameters.
//   A queue-based reference model holds the expected buffer contents, the
//   last accepted word and the overflow flag. Directed steps and a random
//   phase are both checked against this model.
// ---------------------------------------------------------------------------
module tb_cyphertext_fifo;

  localparam int TW = 128;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk_i;
  logic          rst_ni;
  logic          clear_i;
  logic          finish_i;
  logic [TW-1:0] ciphertext_i;
  logic          rd_ready_i;
  logic          rd_valid_o;
  logic [TW-1:0] rd_data_o;
  logic [TW-1:0] last_q_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          overflow_o;

  cyphertext_fifo #(
    .TEXT_WIDTH(TW), .DEPTH(DP), .ADDR_WIDTH(AW), .AF_THRESH(6)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .finish_i(finish_i),
    .ciphertext_i(ciphertext_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .last_q_o(last_q_o),
    .count_o(count_o), .full_o(full_o), .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [TW-1:0] mq[$];
  logic [TW-1:0] m_last;
  logic          m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},    TW'(count_o),    TW'(mq.size()));
    check({tag, ".valid"},    TW'(rd_valid_o), TW'(mq.size() != 0));
    check({tag, ".full"},     TW'(full_o),     TW'(mq.size() == DP));
    check({tag, ".overflow"}, TW'(overflow_o), TW'(m_ovf));
    check({tag, ".last_q"},   last_q_o,        m_last);
  endtask

  // One clock cycle: drive inputs, check the head entry before the edge,
  // update the model, then check registered state just after the edge.
  task automatic step(input logic fin, input logic [TW-1:0] d, input logic rdy,
                      input logic clr, input string tag);
    logic pop;
    logic full;
    finish_i = fin; ciphertext_i = d; rd_ready_i = rdy; clear_i = clr;
    #1;
    if (mq.size() != 0) check({tag, ".head"}, rd_data_o, mq[0]);
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DP);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (fin) begin
        if (!full || pop) begin
          mq.push_back(d);
          m_last = d;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    finish_i = 1'b0; rd_ready_i = 1'b0; clear_i = 1'b0;
    check_state(tag);
  endtask

  function automatic logic [TW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [TW-1:0] aa_word;
  logic [TW-1:0] kat_word;

  initial begin
    mq.delete(); m_last = '0; m_ovf = 1'b0;
    rst_ni = 1'b0; clear_i = 1'b0; finish_i = 1'b0; rd_ready_i = 1'b0;
    ciphertext_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_state("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single pass with a known AES ciphertext
    kat_word = 128'h3925841D02DC09FBDC118597196A0B32;
    step(1'b1, kat_word, 1'b0, 1'b0, "single_push");
    check("single_data", rd_data_o, kat_word);
    step(1'b0, '0, 1'b1, 1'b0, "single_pop");

    // Mid-run asynchronous reset with three entries
    for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0, 1'b0, "prereset");
    #2;
    rst_ni = 1'b0;
    #1;
    mq.delete(); m_last = '0; m_ovf = 1'b0;
    check_state("async_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill with 1..9: the 9th write is dropped, then drain in order
    for (int i = 1; i <= 9; i++) step(1'b1, TW'(i), 1'b0, 1'b0, "fill");
    check("fill_last8", last_q_o, TW'(8));
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", rd_data_o, TW'(i));
      step(1'b0, '0, 1'b1, 1'b0, "drain");
    end

    // Wrap-around with occupancy kept between 1 and 3
    for (int i = 0; i < 20; i++) begin
      logic r;
      if (mq.size() >= 3)      r = 1'b1;
      else if (mq.size() <= 1) r = 1'b0;
      else                     r = 1'($urandom % 2);
      step(1'b1, rnd_word(), r, 1'b0, "wrap");
    end
    while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0, "wrap_drain");

    // Full buffer with a simultaneous push and pop
    for (int i = 0; i < DP; i++) step(1'b1, rnd_word(), 1'b0, 1'b0, "fill2");
    aa_word = {16{8'hAA}};
    step(1'b1, aa_word, 1'b1, 1'b0, "full_pushpop");
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, "pop7");
    check("aa_at_head", rd_data_o, aa_word);
    step(1'b0, '0, 1'b1, 1'b0, "aa_pop");

    // clear_i at count 5, together with push and pop, overflow set beforehand
    for (int i = 0; i < DP + 1; i++) step(1'b1, rnd_word(), 1'b0, 1'b0, "fill3");
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "to5");
    check("pre_clear_count", TW'(count_o), TW'(5));
    step(1'b1, rnd_word(), 1'b1, 1'b1, "clear");
    check("post_clear_count", TW'(count_o), TW'(0));

    // Random traffic, including occasional clears
    for (int i = 0; i < 300; i++) begin
      step(1'(($urandom % 4) != 0), rnd_word(), 1'(($urandom % 3) == 0),
           1'(($urandom % 40) == 0), "random");
    end
    while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
